alu_arbiter: RTL and testbench

- Shares the single 19-bit ALU between two requesters (req0, req1) using round-robin arbitration and valid/ready handshakes.
- Registers the operands and opcode, drives the ALU, and captures its 38-bit result one cycle later.
- Returns the result, with an error flag, to the requester that won arbitration.
- Sits between the instruction-issue logic and the ALU instance. The ALU itself stays external and purely combinational.

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin arbitration on the request side, registered operands/opcode
// toward the ALU, a one-cycle capture of the ALU result, and a held response
// toward whichever requester won the grant.
//
// Handshake rule (all four channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer keeps its payload stable
// while valid is high and not yet accepted; ready never depends on the
// producer's payload, only on valid, the FSM state and the priority pointer.
module alu_arbiter #(
    parameter int DATA_W     = 19,
    parameter int OP_W       = 5,
    parameter int MAX_OPCODE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [OP_W-1:0]       req0_opcode,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [OP_W-1:0]       req1_opcode,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [2*DATA_W-1:0]   rsp0_result,
    output logic                  rsp0_err,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [2*DATA_W-1:0]   rsp1_result,
    output logic                  rsp1_err,

    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OP_W-1:0]       alu_opcode,
    input  logic [2*DATA_W-1:0]   alu_outau,

    output logic                  busy
);

    localparam logic [OP_W-1:0] DIV_OPCODE = OP_W'(3);
    localparam logic [OP_W-1:0] MAX_OP     = OP_W'(MAX_OPCODE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;       // 0: requester 0 has priority
    logic                owner_q, owner_d;   // requester being served
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                err_q, err_d;

    logic                any_valid;
    logic                grant_sel;          // index of the arbitration winner
    logic                accept;
    logic                op_illegal;
    logic                div_by_zero;
    logic                rsp_fire;

    // Arbitration: a lone requester wins outright, contention goes to the pointer.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ptr_q;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
        accept = (state_q == ST_IDLE) && any_valid;
    end

    // Request-side ready; held low while reset is asserted so every output reads 0.
    always_comb begin
        req0_ready = rst_n && accept && !grant_sel;
        req1_ready = rst_n && accept &&  grant_sel;
    end

    // Error classification of the operation currently presented to the ALU.
    always_comb begin
        op_illegal  = (alu_op_q > MAX_OP);
        div_by_zero = (alu_op_q == DIV_OPCODE) && (alu_b_q == '0);
    end

    // Response-side outputs: only the owner sees the held result, the other reads 0.
    always_comb begin
        rsp0_valid  = (state_q == ST_RESP) && !owner_q;
        rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
        rsp0_result = owner_q ? '0 : result_q;
        rsp1_result = owner_q ? result_q : '0;
        rsp0_err    = !owner_q && err_q;
        rsp1_err    =  owner_q && err_q;
        rsp_fire    = owner_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
        busy        = (state_q != ST_IDLE);
        alu_a       = alu_a_q;
        alu_b       = alu_b_q;
        alu_opcode  = alu_op_q;
    end

    // Next-state and datapath-update logic; every register defaults to holding.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = grant_sel;
                    if (grant_sel) begin
                        alu_a_d  = req1_a;
                        alu_b_d  = req1_b;
                        alu_op_d = req1_opcode;
                    end else begin
                        alu_a_d  = req0_a;
                        alu_b_d  = req0_b;
                        alu_op_d = req0_opcode;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Faulted operations return 0 regardless of what the ALU produced.
                if (op_illegal || div_by_zero) begin
                    err_d    = 1'b1;
                    result_d = '0;
                end else begin
                    err_d    = 1'b0;
                    result_d = alu_outau;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Pointer moves only when a response completes, giving strict alternation.
                if (rsp_fire) begin
                    ptr_d   = ~owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, pointer and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Operand, opcode, result and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed operations with hand-computed results,
// expected responses queued on issue and checked by an independent monitor.
module tb_alu_arbiter;

    localparam int DATA_W = 19;
    localparam int OP_W   = 5;
    localparam int RES_W  = 2 * DATA_W;
    localparam int W      = RES_W + 2;   // {owner, err, result}

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OP_W-1:0]   req0_opcode, req1_opcode;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [RES_W-1:0]  rsp0_result, rsp1_result;
    logic              rsp0_err, rsp1_err;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [OP_W-1:0]   alu_opcode;
    logic [RES_W-1:0]  alu_outau;
    logic              busy;

    logic [W-1:0] exp_q[$];
    int n_tests;
    int n_fail;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .MAX_OPCODE(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_opcode (req0_opcode),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_opcode (req1_opcode),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_err    (rsp0_err),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_err    (rsp1_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_outau   (alu_outau),
        .busy        (busy)
    );

    // Stand-in ALU. Faulting cases deliberately return non-zero garbage.
    always_comb begin
        alu_outau = 38'h3A5A5;
        case (alu_opcode)
            5'd0: alu_outau = RES_W'(alu_a) + RES_W'(alu_b);
            5'd1: alu_outau = RES_W'(alu_a) - RES_W'(alu_b);
            5'd2: alu_outau = RES_W'(alu_a) * RES_W'(alu_b);
            5'd3: alu_outau = (alu_b == '0) ? '1 : RES_W'(alu_a / alu_b);
            5'd4: alu_outau = RES_W'(alu_a & alu_b);
            5'd8: alu_outau = RES_W'(alu_a);
            default: alu_outau = 38'h3A5A5;
        endcase
    end

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_opcode = '0;
        req1_a = '0; req1_b = '0; req1_opcode = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                  rsp0_err, rsp1_err, busy}), 64'd0);
        check({tag, "_rsp0_result"}, 64'(rsp0_result), 64'd0);
        check({tag, "_rsp1_result"}, 64'(rsp1_result), 64'd0);
        check({tag, "_alu_in"}, 64'({alu_a, alu_b, alu_opcode}), 64'd0);
    endtask

    // Driver: offer one operation on a port; optionally queue its expected response at acceptance.
    task automatic issue(input int port, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [OP_W-1:0] op, input logic [RES_W-1:0] exp_res,
                         input logic exp_err, input bit push_exp);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        if (port == 0) begin
            req0_a = a; req0_b = b; req0_opcode = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_opcode = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) begin
                @(posedge clk);
                if (push_exp) exp_q.push_back({1'(port), exp_err, exp_res});
                #1;
                if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            check($sformatf("accept_timeout_port%0d", port), 64'd0, 64'd1);
            if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
    endtask

    // Wait for all queued responses to come back and the block to go idle.
    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_drain_timeout"}, 64'(cyc >= 100), 64'd0);
    endtask

    // Monitor: on every completed response handshake, pop and compare.
    task automatic pop_and_compare(input logic port, input logic [RES_W-1:0] res, input logic err);
        logic [W-1:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rsp: port %0d result %0h err %0b with nothing expected",
                     port, res, err);
        end else begin
            e = exp_q.pop_front();
            if ({port, err, res} !== e) begin
                n_fail++;
                $display("FAIL rsp_compare: got owner %0d err %0b result %0h, expected owner %0d err %0b result %0h",
                         port, err, res, e[W-1], e[W-2], e[RES_W-1:0]);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp0_valid && rsp1_valid) begin
                    check("both_rsp_valid", 64'd1, 64'd0);
                end
                if (rsp0_valid && rsp0_ready) pop_and_compare(1'b0, rsp0_result, rsp0_err);
                if (rsp1_valid && rsp1_ready) pop_and_compare(1'b1, rsp1_result, rsp1_err);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        check_all_zero("reset");

        // Single requester: add 5+7, with latency and isolation checks.
        do_reset();
        fork
            issue(0, 19'd5, 19'd7, 5'd0, 38'd12, 1'b0, 1'b1);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t1_req0_ready_first_cycle", 64'({req0_ready, req1_ready}), 64'b10);
                @(negedge clk);
                check("t1_exec_busy_no_rsp", 64'({busy, rsp0_valid}), 64'b10);
                @(negedge clk);
                check("t1_rsp0_valid_after_2", 64'({rsp0_valid, rsp1_valid}), 64'b10);
            end
        join
        drain("t1");

        // Contention from reset: req0 then req1, then req0 again.
        do_reset();
        exp_q.push_back({1'b0, 1'b0, 38'hFFFFE});
        exp_q.push_back({1'b1, 1'b0, 38'd7});
        fork
            issue(0, 19'h7FFFF, 19'd2, 5'd2, '0, 1'b0, 1'b0);
            issue(1, 19'd10, 19'd3, 5'd1, '0, 1'b0, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t2_first_grant_req0", 64'({req0_ready, req1_ready}), 64'b10);
            end
        join
        drain("t2a");
        exp_q.push_back({1'b0, 1'b0, 38'd2});
        exp_q.push_back({1'b1, 1'b0, 38'd4});
        fork
            issue(0, 19'd1, 19'd1, 5'd0, '0, 1'b0, 1'b0);
            issue(1, 19'd2, 19'd2, 5'd0, '0, 1'b0, 1'b0);
        join
        drain("t2b");

        // Divide and opcode-range boundaries.
        issue(1, 19'd100, 19'd0, 5'd3, 38'd0, 1'b1, 1'b1);
        drain("div0");
        issue(1, 19'd100, 19'd7, 5'd3, 38'd14, 1'b0, 1'b1);
        drain("div");
        issue(0, 19'd1, 19'd2, 5'h1F, 38'd0, 1'b1, 1'b1);
        drain("op31");
        issue(0, 19'd1, 19'd2, 5'd9, 38'd0, 1'b1, 1'b1);
        drain("op9");
        issue(0, 19'h1234, 19'd0, 5'd8, 38'h1234, 1'b0, 1'b1);
        drain("op8");

        // Response backpressure on req0 while req1 waits.
        rsp0_ready = 1'b0;
        issue(0, 19'd3, 19'd4, 5'd0, 38'd7, 1'b0, 1'b1);
        fork
            issue(1, 19'd6, 19'd3, 5'd4, 38'd2, 1'b0, 1'b1);
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check($sformatf("bp_hold_%0d", i),
                          64'({rsp0_valid, req1_ready, rsp0_err, rsp0_result}),
                          64'({1'b1, 1'b0, 1'b0, 38'd7}));
                end
                check("bp_alu_in_held", 64'({alu_a, alu_b, alu_opcode}),
                      64'({19'd3, 19'd4, 5'd0}));
                @(posedge clk); #1;
                rsp0_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_req1_next_idle", 64'({busy, req1_ready, req0_ready}), 64'b010);
            end
        join
        drain("bp");

        // Reset during EXEC abandons the operation.
        issue(0, 19'd20, 19'd22, 5'd0, 38'd42, 1'b0, 1'b0);
        check("mid_in_exec", 64'(busy), 64'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_quiet_%0d", i), 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
        end
        exp_q.push_back({1'b0, 1'b0, 38'd2});
        exp_q.push_back({1'b1, 1'b0, 38'd4});
        fork
            issue(0, 19'd1, 19'd1, 5'd0, '0, 1'b0, 1'b0);
            issue(1, 19'd2, 19'd2, 5'd0, '0, 1'b0, 1'b0);
            begin
                @(posedge clk);
                @(negedge clk);
                check("post_reset_grant_req0", 64'({req0_ready, req1_ready}), 64'b10);
            end
        join
        drain("post_reset");

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
